// File: rtl/flood_pkg.sv
// Shared types and constants for the Flood-It game controller.
package flood_pkg;

  typedef enum logic [2:0] {
    S_SIZE,
    S_COLOR,
    S_CALC,
    S_PLAY,
    S_END
  } state_t;

  localparam int unsigned TRY_CAP    = 99;
  localparam int unsigned BUDGET_NUM = 25;
  localparam int unsigned BUDGET_DEN = 84;
  localparam int unsigned PROD_W     = 12;

  // Budget numerator: board edge * colours * BUDGET_NUM, fits in PROD_W bits.
  function automatic logic [PROD_W-1:0] budget_product(input logic [4:0] edge_len,
                                                       input logic [3:0] colors);
    return PROD_W'(edge_len) * PROD_W'(colors) * PROD_W'(BUDGET_NUM);
  endfunction

endpackage

// File: rtl/const_div_seq.sv
// Restoring shift-subtract divider by a constant; one quotient bit per cycle,
// done pulses W cycles after an accepted start, quotient held until next start.
module const_div_seq #(
  parameter int unsigned W   = 12,
  parameter int unsigned DEN = 84
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned RW = $clog2(DEN);
  localparam int unsigned CW = $clog2(W);

  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [RW:0]   trial;
  logic          fits;

  assign trial = {rem, quotient[W-1]};
  assign fits  = (trial >= (RW+1)'(DEN));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          quotient <= dividend;
          rem      <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
        end
      end else begin
        // Dividend bits shift out the top as quotient bits shift in the bottom.
        rem      <= fits ? RW'(trial - (RW+1)'(DEN)) : trial[RW-1:0];
        quotient <= {quotient[W-2:0], fits};
        cnt      <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/flood_game_ctrl.sv
// Flood-It setup / try-count controller feeding the digit display.
// Optional macro FLOOD_UNLIMITED_TRIES_EN: no budget limit, game ends only when solved.
module flood_game_ctrl
  import flood_pkg::*;
#(
  parameter int unsigned SIZE_MIN  = 2,
  parameter int unsigned SIZE_MAX  = 20,
  parameter int unsigned SIZE_DEF  = 14,
  parameter int unsigned COLOR_MIN = 3,
  parameter int unsigned COLOR_MAX = 8,
  parameter int unsigned COLOR_DEF = 6
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_SEL,
  input  logic       BTN_START,
  input  logic       MOVE_VALID,
  input  logic       GAME_DONE,
  output logic [3:0] COLOR_NUM,
  output logic [4:0] SIZE,
  output logic       selecting,
  output logic       sORc,
  output logic       MODE,
  output logic [7:0] TRIES,
  output logic [7:0] TOTAL_TRIES,
  output logic       GAME_OVER,
  output logic       WIN
);

  state_t              state, next_state;
  logic                div_start, div_done;
  logic [PROD_W-1:0]   div_q;
  logic [7:0]          tries_inc;
  logic                budget_hit;
  logic [4:0]          size_up, size_dn;
  logic [3:0]          color_up, color_dn;

  assign div_start = (state == S_SIZE || state == S_COLOR) && BTN_START;
  assign tries_inc = (TRIES >= 8'(TRY_CAP)) ? 8'(TRY_CAP) : TRIES + 8'd1;

`ifdef FLOOD_UNLIMITED_TRIES_EN
  assign budget_hit = 1'b0;
`else
  assign budget_hit = (tries_inc == TOTAL_TRIES);
`endif

  assign size_up  = (SIZE == 5'(SIZE_MAX)) ? 5'(SIZE_MIN) : SIZE + 5'd1;
  assign size_dn  = (SIZE == 5'(SIZE_MIN)) ? 5'(SIZE_MAX) : SIZE - 5'd1;
  assign color_up = (COLOR_NUM == 4'(COLOR_MAX)) ? 4'(COLOR_MIN) : COLOR_NUM + 4'd1;
  assign color_dn = (COLOR_NUM == 4'(COLOR_MIN)) ? 4'(COLOR_MAX) : COLOR_NUM - 4'd1;

  const_div_seq #(
    .W   (PROD_W),
    .DEN (BUDGET_DEN)
  ) u_div (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .start    (div_start),
    .dividend (budget_product(SIZE, COLOR_NUM)),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_SIZE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_SIZE:  if (BTN_START) next_state = S_CALC;
               else if (BTN_SEL) next_state = S_COLOR;
      S_COLOR: if (BTN_START) next_state = S_CALC;
               else if (BTN_SEL) next_state = S_SIZE;
      S_CALC:  if (div_done) next_state = S_PLAY;
      S_PLAY:  if (BTN_START) next_state = S_SIZE;
               else if (GAME_DONE) next_state = S_END;
               else if (MOVE_VALID && budget_hit) next_state = S_END;
      S_END:   if (BTN_START) next_state = S_SIZE;
      default: next_state = S_SIZE;
    endcase
  end

  // Flags follow next_state so every output lands on the same edge as the state change.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      COLOR_NUM   <= 4'(COLOR_DEF);
      SIZE        <= 5'(SIZE_DEF);
      selecting   <= 1'b1;
      sORc        <= 1'b1;
      MODE        <= 1'b0;
      TRIES       <= '0;
      TOTAL_TRIES <= '0;
      GAME_OVER   <= 1'b0;
      WIN         <= 1'b0;
    end else begin
      selecting <= (next_state == S_SIZE) || (next_state == S_COLOR);
      MODE      <= (next_state == S_PLAY) || (next_state == S_END);
      GAME_OVER <= (next_state == S_END);
      if (next_state == S_SIZE)       sORc <= 1'b1;
      else if (next_state == S_COLOR) sORc <= 1'b0;

      unique case (state)
        S_SIZE: begin
          if (BTN_START)      TRIES <= '0;
          else if (BTN_SEL)   ;
          else if (BTN_UP)    SIZE <= size_up;
          else if (BTN_DOWN)  SIZE <= size_dn;
        end
        S_COLOR: begin
          if (BTN_START)      TRIES <= '0;
          else if (BTN_SEL)   ;
          else if (BTN_UP)    COLOR_NUM <= color_up;
          else if (BTN_DOWN)  COLOR_NUM <= color_dn;
        end
        S_CALC: begin
          if (div_done)
            TOTAL_TRIES <= (div_q > PROD_W'(TRY_CAP)) ? 8'(TRY_CAP) : div_q[7:0];
        end
        S_PLAY: begin
          if (!BTN_START && MOVE_VALID) TRIES <= tries_inc;
          if (next_state == S_END)      WIN   <= GAME_DONE;
        end
        S_END: begin
          if (next_state == S_SIZE) WIN <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_game_ctrl.sv
// Scoreboard bench for flood_game_ctrl: driver pushes model predictions, monitor compares each cycle.
module tb_flood_game_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_SEL = 1'b0, BTN_START = 1'b0;
  logic       MOVE_VALID = 1'b0, GAME_DONE = 1'b0;
  logic [3:0] COLOR_NUM;
  logic [4:0] SIZE;
  logic       selecting, sORc, MODE, GAME_OVER, WIN;
  logic [7:0] TRIES, TOTAL_TRIES;

  flood_game_ctrl #(
    .SIZE_MIN (2), .SIZE_MAX (20), .SIZE_DEF (14),
    .COLOR_MIN(3), .COLOR_MAX(8),  .COLOR_DEF(6)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_SEL(BTN_SEL), .BTN_START(BTN_START),
    .MOVE_VALID(MOVE_VALID), .GAME_DONE(GAME_DONE),
    .COLOR_NUM(COLOR_NUM), .SIZE(SIZE), .selecting(selecting), .sORc(sORc),
    .MODE(MODE), .TRIES(TRIES), .TOTAL_TRIES(TOTAL_TRIES),
    .GAME_OVER(GAME_OVER), .WIN(WIN)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [3:0] color;
    logic [4:0] size;
    logic       sel;
    logic       sorc;
    logic       mode;
    logic [7:0] tries;
    logic [7:0] total;
    logic       over;
    logic       win;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass = 0, n_total = 0;

  // Reference model: game phase plus plain-integer game variables.
  localparam int PH_SETUP = 0, PH_CALC = 1, PH_PLAY = 2, PH_END = 3;
  int  phase = PH_SETUP;
  int  m_size = 14, m_color = 6, m_tries = 0, m_total = 0, budget = 0, wait_cnt = 0;
  bit  m_edit_size = 1, m_setup = 1, m_mode = 0, m_over = 0, m_win = 0;
  bit  rst_v = 1;

  function automatic obs_t snap_model();
    obs_t o;
    o.color = 4'(m_color); o.size = 5'(m_size); o.sel = m_setup; o.sorc = m_edit_size;
    o.mode = m_mode; o.tries = 8'(m_tries); o.total = 8'(m_total);
    o.over = m_over; o.win = m_win;
    return o;
  endfunction

  function automatic obs_t snap_dut();
    obs_t o;
    o.color = COLOR_NUM; o.size = SIZE; o.sel = selecting; o.sorc = sORc;
    o.mode = MODE; o.tries = TRIES; o.total = TOTAL_TRIES; o.over = GAME_OVER; o.win = WIN;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("col=%0d size=%0d sel=%0d sORc=%0d mode=%0d tries=%0d total=%0d over=%0d win=%0d",
                     o.color, o.size, o.sel, o.sorc, o.mode, o.tries, o.total, o.over, o.win);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got {%s} required {%s}", name, $time, fmt(got), fmt(exp));
  endtask

  task automatic to_setup();
    phase = PH_SETUP; m_setup = 1; m_edit_size = 1; m_mode = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model(input bit up, dn, sl, st, mv, gd);
    if (rst_v) begin
      to_setup();
      m_size = 14; m_color = 6; m_tries = 0; m_total = 0;
      return;
    end
    case (phase)
      PH_SETUP: begin
        if (st) begin
          phase = PH_CALC; wait_cnt = 13; m_tries = 0; m_setup = 0;
          budget = (m_size * m_color * 25) / 84;
          if (budget > 99) budget = 99;
        end else if (sl) m_edit_size = !m_edit_size;
        else if (up) begin
          if (m_edit_size) m_size = (m_size == 20) ? 2 : m_size + 1;
          else             m_color = (m_color == 8) ? 3 : m_color + 1;
        end else if (dn) begin
          if (m_edit_size) m_size = (m_size == 2) ? 20 : m_size - 1;
          else             m_color = (m_color == 3) ? 8 : m_color - 1;
        end
      end
      PH_CALC: begin
        wait_cnt--;
        if (wait_cnt == 0) begin phase = PH_PLAY; m_mode = 1; m_total = budget; end
      end
      PH_PLAY: begin
        if (st) to_setup();
        else begin
          if (mv && m_tries < 99) m_tries++;
          if (gd) begin phase = PH_END; m_over = 1; m_win = 1; end
          else if (mv && m_tries == m_total) begin phase = PH_END; m_over = 1; m_win = 0; end
        end
      end
      default: if (st) to_setup();
    endcase
  endtask

  task automatic step(input bit up = 0, dn = 0, sl = 0, st = 0, mv = 0, gd = 0);
    @(negedge CLOCK);
    RESET = rst_v; BTN_UP = up; BTN_DOWN = dn; BTN_SEL = sl; BTN_START = st;
    MOVE_VALID = mv; GAME_DONE = gd;
    model(up, dn, sl, st, mv, gd);
    exp_q.push_back(snap_model());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every cycle the DUT presents a new output word just after the edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", snap_dut(), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t rst_exp;
    rst_exp = '{color: 4'd6, size: 5'd14, sel: 1'b1, sorc: 1'b1, mode: 1'b0,
                tries: 8'd0, total: 8'd0, over: 1'b0, win: 1'b0};

    rst_v = 1; idle(2);
    rst_v = 0; idle(1);

    for (int i = 0; i < 7; i++) step(.up(1));          // 14 -> 20 -> 2
    step(.sl(1));
    for (int i = 0; i < 4; i++) step(.dn(1));          // 6 -> 5,4,3,8
    step(.sl(1), .up(1));                              // toggle only
    step(.dn(1), .up(1));                              // UP beats DOWN

    rst_v = 1; idle(1); rst_v = 0;
    step(.st(1));
    step(.up(1), .mv(1), .sl(1));                      // ignored in CALC
    idle(13);
    for (int i = 0; i < 25; i++) begin step(.mv(1)); step(); end
    step(.mv(1)); step(.up(1));
    step(.st(1));

    for (int i = 0; i < 6; i++) step(.up(1));          // size 20
    step(.sl(1)); step(.up(1)); step(.up(1));          // colours 8
    step(.st(1)); idle(14);
    for (int i = 0; i < 3; i++) step(.mv(1));
    step(.mv(1), .gd(1));
    idle(1);
    step(.st(1));

    step(.st(1)); idle(5);
    @(posedge CLOCK); #3;
    rst_v = 1; RESET = 1'b1;
    #1 check("async_reset", snap_dut(), rst_exp);
    idle(1);
    rst_v = 0;
    step(.st(1)); idle(14);
    step(.mv(1)); step(.gd(1)); step(.st(1));

    for (int i = 0; i < 600; i++)
      step(.up($urandom_range(0, 5) == 0), .dn($urandom_range(0, 5) == 0),
           .sl($urandom_range(0, 9) == 0), .st($urandom_range(0, 49) == 0),
           .mv($urandom_range(0, 1) == 0), .gd($urandom_range(0, 39) == 0));

    step();
    repeat (3) @(posedge CLOCK);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
